// File: rtl/p5_write_back.sv
// p5_write_back: phase-5 (write-back) stage of the multi-cycle SIMPLE processor.
// Commits the ALU result (ar) or the phase-4 MDR value to the register file,
// latches the OUT display register, the sticky halt flag and a retired count.
// State updates on the falling clock edge; asynchronous active-low reset.
// Optional macro WB_BYPASS_EN: read ports forward the value being written
// in the current write-back phase instead of the stale stored contents.
module p5_write_back #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        state,
  input  logic              op_reg_write,
  input  logic              op_wb_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] ar,
  input  logic [DATA_W-1:0] mdr,
  input  logic              op_out,
  input  logic              op_halt,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] out_reg,
  output logic              halt,
  output logic [15:0]       retired,
  output logic [DATA_W-1:0] wb_data_out
);

  typedef enum logic [2:0] {
    PH_MEM = 3'b100,
    PH_WB  = 3'b101
  } phase_e;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] out_q, out_d;
  logic              halt_q, halt_d;
  logic [15:0]       retired_q, retired_d;
  logic              active;
  logic              wr_en;

  // Write-back mux and per-phase enables; a halted core retires nothing.
  always_comb begin
    wb_data_out = op_wb_sel ? mdr : ar;
    active      = (state == PH_WB) && !halt_q;
    wr_en       = active && op_reg_write;
    out_d       = out_q;
    halt_d      = halt_q;
    retired_d   = retired_q;
    if (active) begin
      retired_d = retired_q + 16'd1;
      if (op_out) begin
        out_d = ar;
      end
    end
    // Halt is sampled even when already halted; it is sticky until reset.
    if (state == PH_WB && op_halt) begin
      halt_d = 1'b1;
    end
  end

  // Architectural state: register file, OUT, halt and retired counter.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      out_q     <= '0;
      halt_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[rd_addr] <= wb_data_out;
      end
      out_q     <= out_d;
      halt_q    <= halt_d;
      retired_q <= retired_d;
    end
  end

  // Combinational read ports, optionally forwarding the in-flight write.
  always_comb begin
    ra_data = regs_q[ra_addr];
    rb_data = regs_q[rb_addr];
`ifdef WB_BYPASS_EN
    if (wr_en && (ra_addr == rd_addr)) begin
      ra_data = wb_data_out;
    end
    if (wr_en && (rb_addr == rd_addr)) begin
      rb_data = wb_data_out;
    end
`else
`endif
  end

  assign out_reg = out_q;
  assign halt    = halt_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_p5_write_back.sv
// Testbench for p5_write_back: table of directed write-back phases plus
// hand-written sequences for async reset, read-port bypass and counter wrap.
module tb_p5_write_back;

  logic        clock;
  logic        reset;
  logic [2:0]  state;
  logic        op_reg_write;
  logic        op_wb_sel;
  logic [2:0]  rd_addr;
  logic [15:0] ar;
  logic [15:0] mdr;
  logic        op_out;
  logic        op_halt;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic [15:0] ra_data;
  logic [15:0] rb_data;
  logic [15:0] out_reg;
  logic        halt;
  logic [15:0] retired;
  logic [15:0] wb_data_out;

  int unsigned n_pass;
  int unsigned n_total;

  p5_write_back #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .state        (state),
    .op_reg_write (op_reg_write),
    .op_wb_sel    (op_wb_sel),
    .rd_addr      (rd_addr),
    .ar           (ar),
    .mdr          (mdr),
    .op_out       (op_out),
    .op_halt      (op_halt),
    .ra_addr      (ra_addr),
    .rb_addr      (rb_addr),
    .ra_data      (ra_data),
    .rb_data      (rb_data),
    .out_reg      (out_reg),
    .halt         (halt),
    .retired      (retired),
    .wb_data_out  (wb_data_out)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  st;
    logic        wr;
    logic        sel;
    logic [2:0]  rd;
    logic [15:0] ar;
    logic [15:0] mdr;
    logic        out;
    logic        hlt;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] e_wb;
    logic [15:0] e_ra;
    logic [15:0] e_rb;
    logic [15:0] e_out;
    logic        e_halt;
    logic [15:0] e_ret;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    state = 3'b000; op_reg_write = 1'b0; op_wb_sel = 1'b0; rd_addr = '0;
    ar = '0; mdr = '0; op_out = 1'b0; op_halt = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_byp;
    n_pass  = 0;
    n_total = 0;
    idle_inputs();
    ra_addr = 3'd0;
    rb_addr = 3'd1;
    reset   = 1'b1;

    //            st      wr    sel   rd    ar        mdr       out   hlt   ra    rb    e_wb      e_ra      e_rb      e_out     e_halt e_ret
    vecs[0] = '{3'b101, 1'b1, 1'b0, 3'd3, 16'h1234, 16'h0000, 1'b0, 1'b0, 3'd3, 3'd0, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1'b0, 16'd1};
    vecs[1] = '{3'b101, 1'b1, 1'b1, 3'd7, 16'h0001, 16'hBEEF, 1'b0, 1'b0, 3'd7, 3'd3, 16'hBEEF, 16'hBEEF, 16'h1234, 16'h0000, 1'b0, 16'd2};
    vecs[2] = '{3'b100, 1'b1, 1'b1, 3'd7, 16'h0002, 16'h1111, 1'b1, 1'b1, 3'd7, 3'd1, 16'h1111, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 16'd2};
    vecs[3] = '{3'b101, 1'b0, 1'b0, 3'd1, 16'h0042, 16'h0000, 1'b1, 1'b0, 3'd1, 3'd3, 16'h0042, 16'h0000, 16'h1234, 16'h0042, 1'b0, 16'd3};
    vecs[4] = '{3'b101, 1'b1, 1'b0, 3'd0, 16'h8001, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd7, 16'h8001, 16'h8001, 16'hBEEF, 16'h0042, 1'b0, 16'd4};
    vecs[5] = '{3'b101, 1'b1, 1'b0, 3'd2, 16'h00FF, 16'h0000, 1'b1, 1'b1, 3'd2, 3'd0, 16'h00FF, 16'h00FF, 16'h8001, 16'h00FF, 1'b1, 16'd5};
    vecs[6] = '{3'b101, 1'b1, 1'b0, 3'd2, 16'h5555, 16'h0000, 1'b1, 1'b0, 3'd2, 3'd7, 16'h5555, 16'h00FF, 16'hBEEF, 16'h00FF, 1'b1, 16'd5};
    vecs[7] = '{3'b101, 1'b1, 1'b1, 3'd5, 16'h0000, 16'h7777, 1'b0, 1'b1, 3'd5, 3'd3, 16'h7777, 16'h0000, 16'h1234, 16'h00FF, 1'b1, 16'd5};

    // Initial asynchronous reset, observed before any clock edge.
    #2 reset = 1'b0;
    #1;
    check("reset_ra",      ra_data, 16'h0000);
    check("reset_out",     out_reg, 16'h0000);
    check("reset_halt",    {15'd0, halt}, 16'h0000);
    check("reset_retired", retired, 16'h0000);
    @(posedge clock); #1 reset = 1'b1;

    // Table-driven write-back phases.
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      state = vecs[i].st; op_reg_write = vecs[i].wr; op_wb_sel = vecs[i].sel;
      rd_addr = vecs[i].rd; ar = vecs[i].ar; mdr = vecs[i].mdr;
      op_out = vecs[i].out; op_halt = vecs[i].hlt;
      ra_addr = vecs[i].ra; rb_addr = vecs[i].rb;
      #1;
      check($sformatf("v%0d_wb", i), wb_data_out, vecs[i].e_wb);
      @(negedge clock); #1;
      check($sformatf("v%0d_ra", i),      ra_data, vecs[i].e_ra);
      check($sformatf("v%0d_rb", i),      rb_data, vecs[i].e_rb);
      check($sformatf("v%0d_out", i),     out_reg, vecs[i].e_out);
      check($sformatf("v%0d_halt", i),    {15'd0, halt}, {15'd0, vecs[i].e_halt});
      check($sformatf("v%0d_retired", i), retired, vecs[i].e_ret);
    end

    // Reset pulsed mid-phase while a write is pending: immediate clear, write aborted.
    @(posedge clock); #1;
    state = 3'b101; op_reg_write = 1'b1; op_wb_sel = 1'b0; rd_addr = 3'd6;
    ar = 16'h9999; op_out = 1'b1; op_halt = 1'b0; ra_addr = 3'd2; rb_addr = 3'd7;
    #1 reset = 1'b0;
    #1;
    check("midreset_ra",      ra_data, 16'h0000);
    check("midreset_rb",      rb_data, 16'h0000);
    check("midreset_out",     out_reg, 16'h0000);
    check("midreset_halt",    {15'd0, halt}, 16'h0000);
    check("midreset_retired", retired, 16'h0000);
    @(negedge clock); #1;
    idle_inputs();
    reset = 1'b1;
    ra_addr = 3'd6;
    #1;
    check("midreset_abort_r6",  ra_data, 16'h0000);
    check("midreset_abort_out", out_reg, 16'h0000);

    // Bypass: the stored value stays visible until the edge unless forwarding is built in.
    @(posedge clock); #1;
    state = 3'b101; op_reg_write = 1'b1; op_wb_sel = 1'b0; rd_addr = 3'd4;
    ar = 16'hA5A5; ra_addr = 3'd4; rb_addr = 3'd4;
`ifdef WB_BYPASS_EN
    exp_byp = 16'hA5A5;
`else
    exp_byp = 16'h0000;
`endif
    #1;
    check("bypass_ra_pre", ra_data, exp_byp);
    check("bypass_rb_pre", rb_data, exp_byp);
    @(negedge clock); #1;
    check("bypass_ra_post", ra_data, 16'hA5A5);
    check("bypass_rb_post", rb_data, 16'hA5A5);
    check("bypass_retired", retired, 16'd1);

    // Retired counter wrap: retired is 1 here; 65534 more visits reach FFFF.
    @(posedge clock); #1;
    idle_inputs();
    state = 3'b101;
    repeat (65534) @(negedge clock);
    #1 state = 3'b000;
    check("wrap_ffff", retired, 16'hFFFF);
    @(posedge clock); #1 state = 3'b101;
    @(negedge clock); #1 state = 3'b000;
    check("wrap_zero", retired, 16'h0000);
    check("wrap_regs_intact", ra_data, 16'hA5A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
